i2c_slave_regs: RTL

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

---
 rtl/i2c_slave_regs.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regs.sv
// I2C responder with a byte-wide register file: pointer write, data writes, and reads.
// Optional pointer auto-increment after each data byte: define I2C_SLAVE_AUTOINC_EN.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scl,
  inout  wire                         sda,
  output logic                        busy,
  output logic                        wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [7:0]                  wr_data
);
  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  state_t          r_state;
  logic            r_scl_s1, r_scl_s2, r_scl_d;
  logic            r_sda_s1, r_sda_s2, r_sda_d;
  logic            r_oe;
  logic            r_busy;
  logic            r_rw;
  logic            r_ack;
  logic [3:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic [6:0]      r_tx;
  logic [AW-1:0]   r_ptr;
  logic            r_wr_pulse;
  logic [AW-1:0]   r_wr_addr;
  logic [7:0]      r_wr_data;
  logic [7:0]      r_regs [NUM_REGS];
  logic [7:0]      r_rd_data;

  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  assign sda      = r_oe ? 1'b0 : 1'bz;
  assign busy     = r_busy;
  assign wr_pulse = r_wr_pulse;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
    end else begin
      r_scl_s1 <= scl;      r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
      r_sda_s1 <= sda;      r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

  // Register file: written one clk after wr_pulse, read port registered off the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
      r_rd_data <= 8'h00;
    end else begin
      if (r_wr_pulse) r_regs[r_wr_addr] <= r_wr_data;
      r_rd_data <= r_regs[r_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_rw       <= 1'b0;
      r_ack      <= 1'b1;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'h00;
      r_tx       <= 7'h00;
      r_ptr      <= '0;
      r_wr_pulse <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'h00;
    end else begin
      r_wr_pulse <= 1'b0;
      if (w_stop) begin
        r_state   <= IDLE;
        r_oe      <= 1'b0;
        r_busy    <= 1'b0;
        r_bit_cnt <= 4'd0;
      end else if (w_start) begin
        r_state   <= DEV_ADDR;
        r_oe      <= 1'b0;
        r_bit_cnt <= 4'd0;
      end else begin
        if (w_scl_rise) begin
          case (r_state)
            DEV_ADDR, REG_PTR, WR_DATA: begin
              r_shift   <= {r_shift[6:0], r_sda_s2};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            RD_DATA: r_bit_cnt <= r_bit_cnt + 4'd1;
            RD_ACK:  r_ack     <= r_sda_s2;
            default: ;
          endcase
        end
        // Byte ends and drive changes are acted on only while scl is low.
        if (w_scl_fall) begin
          case (r_state)
            DEV_ADDR: if (r_bit_cnt == 4'd8) begin
              r_bit_cnt <= 4'd0;
              if (r_shift[7:1] == SLAVE_ADDR) begin
                r_state <= DEV_ACK;
                r_oe    <= 1'b1;
                r_busy  <= 1'b1;
                r_rw    <= r_shift[0];
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end
            DEV_ACK: begin
              r_bit_cnt <= 4'd0;
              if (r_rw) begin
                r_state <= RD_DATA;
                r_tx    <= r_rd_data[6:0];
                r_oe    <= ~r_rd_data[7];
              end else begin
                r_state <= REG_PTR;
                r_oe    <= 1'b0;
              end
            end
            REG_PTR: if (r_bit_cnt == 4'd8) begin
              r_ptr     <= r_shift[AW-1:0];
              r_state   <= PTR_ACK;
              r_oe      <= 1'b1;
              r_bit_cnt <= 4'd0;
            end
            PTR_ACK, WR_ACK: begin
              r_state   <= WR_DATA;
              r_oe      <= 1'b0;
              r_bit_cnt <= 4'd0;
            end
            WR_DATA: if (r_bit_cnt == 4'd8) begin
              r_wr_pulse <= 1'b1;
              r_wr_addr  <= r_ptr;
              r_wr_data  <= r_shift;
`ifdef I2C_SLAVE_AUTOINC_EN
              r_ptr      <= r_ptr + AW'(1);
`else
              r_ptr      <= r_ptr;
`endif
              r_state    <= WR_ACK;
              r_oe       <= 1'b1;
              r_bit_cnt  <= 4'd0;
            end
            RD_DATA: begin
              if (r_bit_cnt == 4'd8) begin
                r_state   <= RD_ACK;
                r_oe      <= 1'b0;
                r_bit_cnt <= 4'd0;
`ifdef I2C_SLAVE_AUTOINC_EN
                r_ptr     <= r_ptr + AW'(1);
`else
                r_ptr     <= r_ptr;
`endif
              end else begin
                r_oe <= ~r_tx[6];
                r_tx <= {r_tx[5:0], 1'b0};
              end
            end
            RD_ACK: begin
              r_bit_cnt <= 4'd0;
              if (!r_ack) begin
                r_state <= RD_DATA;
                r_tx    <= r_rd_data[6:0];
                r_oe    <= ~r_rd_data[7];
              end else begin
                r_state <= IDLE;
                r_oe    <= 1'b0;
              end
            end
            default: r_oe <= 1'b0;
          endcase
        end
      end
    end
  end
endmodule
